// File: rtl/spi_sensor_pkg.sv
// Shared types and defaults for the SPI sensor reader.
// States, default timing, and the field-width helper.
package spi_sensor_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SHIFT,
    HOLD,
    GAP
  } state_t;

  localparam int DEF_FRAME_BITS = 16;
  localparam int DEF_DATA_MSB   = 11;
  localparam int DEF_DATA_LSB   = 4;
  localparam int DEF_CLK_DIV    = 2;
  localparam int DEF_CS_SETUP   = 2;
  localparam int DEF_CS_HOLD    = 2;
  localparam int DEF_GAP_CYCLES = 4;

  function automatic int data_w(input int msb, input int lsb);
    return msb - lsb + 1;
  endfunction

endpackage

// File: rtl/spi_sclk_gen.sv
// SCLK divider: toggles every CLK_DIV cycles while enabled.
// Edge pulses coincide with the clk edge that flips sclk.
module spi_sclk_gen #(
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic sclk,
  output logic rise_pulse,
  output logic fall_pulse
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [CW-1:0] cnt;
  logic          tc;

  assign tc         = en && (cnt == CW'(CLK_DIV - 1));
  assign rise_pulse = tc && !sclk;
  assign fall_pulse = tc && sclk;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt  <= '0;
      sclk <= 1'b1;
    end else if (en) begin
      if (tc) begin
        cnt  <= '0;
        sclk <= ~sclk;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/spi_sensor_reader.sv
// Receive-only SPI master: frames a sensor read and hands
// the extracted field to the consumer via valid/ready.
module spi_sensor_reader
  import spi_sensor_pkg::*;
#(
  parameter int FRAME_BITS = DEF_FRAME_BITS,
  parameter int DATA_MSB   = DEF_DATA_MSB,
  parameter int DATA_LSB   = DEF_DATA_LSB,
  parameter int CLK_DIV    = DEF_CLK_DIV,
  parameter int CS_SETUP   = DEF_CS_SETUP,
  parameter int CS_HOLD    = DEF_CS_HOLD,
  parameter int GAP_CYCLES = DEF_GAP_CYCLES,
  localparam int DATA_W    = data_w(DATA_MSB, DATA_LSB)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  continuous,
  output logic                  busy,
  output logic                  cs_n,
  output logic                  sclk,
  input  logic                  miso,
  output logic [DATA_W-1:0]     data,
  output logic [FRAME_BITS-1:0] raw,
  output logic                  data_valid,
  input  logic                  data_ready,
  output logic                  overrun,
  output logic [15:0]           frame_cnt
);

  localparam int BW = $clog2(FRAME_BITS + 1);

  if (FRAME_BITS < 2 || FRAME_BITS > 32) begin : g_bad_fb
    $error("FRAME_BITS must be 2..32");
  end
  if (DATA_MSB >= FRAME_BITS) begin : g_bad_msb
    $error("DATA_MSB must be below FRAME_BITS");
  end
  if (DATA_LSB > DATA_MSB || DATA_LSB < 0) begin : g_bad_lsb
    $error("DATA_LSB must be 0..DATA_MSB");
  end
  if (CLK_DIV < 1 || CS_SETUP < 1 ||
      CS_HOLD < 1 || GAP_CYCLES < 1) begin : g_bad_tim
    $error("timing parameters must be >= 1");
  end

  state_t                state;
  logic [15:0]           cnt;
  logic [BW-1:0]         bit_cnt;
  logic [FRAME_BITS-1:0] sr;
  logic                  rise;
  logic                  in_shift;

  assign in_shift = (state == SHIFT);

  spi_sclk_gen #(
    .CLK_DIV(CLK_DIV)
  ) u_sclk (
    .clk       (clk),
    .rst       (rst),
    .en        (in_shift),
    .clr       (!in_shift),
    .sclk      (sclk),
    .rise_pulse(rise),
    .fall_pulse()
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      busy       <= 1'b0;
      cs_n       <= 1'b1;
      cnt        <= '0;
      bit_cnt    <= '0;
      sr         <= '0;
      raw        <= '0;
      data       <= '0;
      data_valid <= 1'b0;
      overrun    <= 1'b0;
      frame_cnt  <= '0;
    end else begin
      if (data_valid && data_ready) data_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            state <= SETUP;
            cs_n  <= 1'b0;
            busy  <= 1'b1;
            cnt   <= '0;
          end
        end
        SETUP: begin
          if (cnt == 16'(CS_SETUP - 1)) begin
            state <= SHIFT;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        SHIFT: begin
          if (rise) begin
            sr <= {sr[FRAME_BITS-2:0], miso};
            if (bit_cnt == BW'(FRAME_BITS - 1)) begin
              bit_cnt <= '0;
              state   <= HOLD;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
        end
        HOLD: begin
          if (cnt == 16'(CS_HOLD - 1)) begin
            cnt        <= '0;
            cs_n       <= 1'b1;
            raw        <= sr;
            data       <= sr[DATA_MSB:DATA_LSB];
            data_valid <= 1'b1;
            frame_cnt  <= frame_cnt + 1'b1;
            // a same-edge accept consumes the old sample
            if (data_valid && !data_ready) overrun <= 1'b1;
            if (continuous) begin
              state <= GAP;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        GAP: begin
          if (cnt == 16'(GAP_CYCLES - 1)) begin
            state <= SETUP;
            cs_n  <= 1'b0;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_sensor_reader.sv
// Directed bench with a sensor model and raw-frame scoreboard.
// Covers defaults plus a 12-bit CLK_DIV=1 configuration.
module tb_spi_sensor_reader;

  logic clk;
  logic rst;

  logic        start0, cont0, miso0, ready0;
  logic        busy0, cs_n0, sclk0, dv0, ovr0;
  logic [7:0]  data0;
  logic [15:0] raw0, fcnt0;

  logic        start1, cont1, miso1, ready1;
  logic        busy1, cs_n1, sclk1, dv1, ovr1;
  logic [11:0] data1;
  logic [11:0] raw1;
  logic [15:0] fcnt1;

  int checks;
  int failures;

  logic [15:0] tx0;
  logic [11:0] tx1;
  int          bit0, bit1;
  int          rise0, rise1, low0, low1;
  int          rb, lb, gap;
  logic [15:0] exp_q[$];
  logic [15:0] e;

  spi_sensor_reader u_dut0 (
    .clk       (clk),
    .rst       (rst),
    .start     (start0),
    .continuous(cont0),
    .busy      (busy0),
    .cs_n      (cs_n0),
    .sclk      (sclk0),
    .miso      (miso0),
    .data      (data0),
    .raw       (raw0),
    .data_valid(dv0),
    .data_ready(ready0),
    .overrun   (ovr0),
    .frame_cnt (fcnt0)
  );

  spi_sensor_reader #(
    .FRAME_BITS(12),
    .DATA_MSB  (11),
    .DATA_LSB  (0),
    .CLK_DIV   (1),
    .CS_SETUP  (2),
    .CS_HOLD   (2),
    .GAP_CYCLES(4)
  ) u_dut1 (
    .clk       (clk),
    .rst       (rst),
    .start     (start1),
    .continuous(cont1),
    .busy      (busy1),
    .cs_n      (cs_n1),
    .sclk      (sclk1),
    .miso      (miso1),
    .data      (data1),
    .raw       (raw1),
    .data_valid(dv1),
    .data_ready(ready1),
    .overrun   (ovr1),
    .frame_cnt (fcnt1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // sensor: cs_n falls with sclk high, bits change on sclk falls
  always @(negedge sclk0 or negedge cs_n0) begin
    if (sclk0 === 1'b1) begin
      bit0 = 15;
    end else if (cs_n0 === 1'b0 && bit0 >= 0) begin
      miso0 = tx0[bit0];
      bit0  = bit0 - 1;
    end
  end

  always @(negedge sclk1 or negedge cs_n1) begin
    if (sclk1 === 1'b1) begin
      bit1 = 11;
    end else if (cs_n1 === 1'b0 && bit1 >= 0) begin
      miso1 = tx1[bit1];
      bit1  = bit1 - 1;
    end
  end

  always @(posedge sclk0) rise0 = rise0 + 1;
  always @(posedge sclk1) rise1 = rise1 + 1;
  always @(posedge clk) if (cs_n0 === 1'b0) low0 = low0 + 1;
  always @(posedge clk) if (cs_n1 === 1'b0) low1 = low1 + 1;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit cond(input int sel, input int n);
    case (sel)
      0: return dv0 === 1'b1;
      1: return cs_n0 === 1'b1;
      2: return cs_n0 === 1'b0;
      3: return (rise0 - rb) >= n;
      default: return dv1 === 1'b1;
    endcase
  endfunction

  task automatic wait_for(input int sel, input int n, input int budget);
    for (int i = 0; i < budget; i++) begin
      @(posedge clk); #1;
      if (cond(sel, n)) return;
    end
    checks++;
    failures++;
    $error("FAIL timeout sel=%0d observed=expired expected=event", sel);
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic pulse_start0();
    start0 = 1'b1;
    step(1);
    start0 = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(2);
    rst = 1'b0;
  endtask

  task automatic pop_raw(input string tag);
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $error("FAIL %s observed=empty expected=entry", tag);
    end else begin
      e = exp_q.pop_front();
      checks--;
      chk(tag, 32'(raw0), 32'(e));
    end
  endtask

  initial begin
    checks = 0; failures = 0;
    rise0 = 0; rise1 = 0; low0 = 0; low1 = 0;
    bit0 = 15; bit1 = 11;
    miso0 = 1'b0; miso1 = 1'b0;
    tx0 = '0; tx1 = '0;
    start0 = 0; cont0 = 0; ready0 = 0;
    start1 = 0; cont1 = 0; ready1 = 0;
    rst = 1'b1;
    step(3);
    rst = 1'b0;

    chk("rst_csn", 32'(cs_n0), 32'd1);
    chk("rst_sclk", 32'(sclk0), 32'd1);
    chk("rst_busy", 32'(busy0), 32'd0);
    chk("rst_data", 32'(data0), 32'd0);
    chk("rst_raw", 32'(raw0), 32'd0);
    chk("rst_dv", 32'(dv0), 32'd0);
    chk("rst_ovr", 32'(ovr0), 32'd0);
    chk("rst_fcnt", 32'(fcnt0), 32'd0);

    // single shot
    tx0 = 16'hABCD;
    exp_q.push_back(16'hABCD);
    lb = low0; rb = rise0;
    pulse_start0();
    chk("ss_csn_low", 32'(cs_n0), 32'd0);
    chk("ss_busy", 32'(busy0), 32'd1);
    wait_for(0, 0, 200);
    chk("ss_low_cyc", 32'(low0 - lb), 32'd68);
    chk("ss_rises", 32'(rise0 - rb), 32'd16);
    pop_raw("ss_raw");
    chk("ss_data", 32'(data0), 32'hBC);
    chk("ss_fcnt", 32'(fcnt0), 32'd1);
    chk("ss_busy_fall", 32'(busy0), 32'd0);
    chk("ss_csn_high", 32'(cs_n0), 32'd1);

    // handshake
    step(10);
    chk("hs_hold_dv", 32'(dv0), 32'd1);
    ready0 = 1'b1;
    step(1);
    ready0 = 1'b0;
    chk("hs_dv_drop", 32'(dv0), 32'd0);
    chk("hs_data", 32'(data0), 32'hBC);
    chk("hs_ovr", 32'(ovr0), 32'd0);

    // continuous with overrun
    do_reset();
    cont0 = 1'b1;
    tx0 = 16'h1230;
    exp_q.push_back(16'h1230);
    pulse_start0();
    wait_for(0, 0, 200);
    pop_raw("c1_raw");
    chk("c1_data", 32'(data0), 32'h23);
    chk("c1_ovr", 32'(ovr0), 32'd0);
    chk("c1_busy", 32'(busy0), 32'd1);
    tx0 = 16'h4560;
    exp_q.push_back(16'h4560);
    gap = 0;
    while (cs_n0 === 1'b1 && gap < 50) begin
      gap++;
      step(1);
    end
    chk("c_gap", 32'(gap), 32'd4);
    step(20);
    cont0 = 1'b0;
    wait_for(1, 0, 200);
    pop_raw("c2_raw");
    chk("c2_data", 32'(data0), 32'h56);
    chk("c2_ovr", 32'(ovr0), 32'd1);
    chk("c2_fcnt", 32'(fcnt0), 32'd2);
    chk("c2_dv", 32'(dv0), 32'd1);
    step(10);
    chk("c_idle_csn", 32'(cs_n0), 32'd1);
    chk("c_idle_busy", 32'(busy0), 32'd0);

    // accept coincident with frame store
    do_reset();
    cont0 = 1'b1;
    tx0 = 16'h1111;
    exp_q.push_back(16'h1111);
    pulse_start0();
    wait_for(0, 0, 200);
    pop_raw("co1_raw");
    tx0 = 16'h2222;
    exp_q.push_back(16'h2222);
    step(71);
    chk("co_pre_dv", 32'(dv0), 32'd1);
    ready0 = 1'b1;
    step(1);
    ready0 = 1'b0;
    chk("co_dv", 32'(dv0), 32'd1);
    chk("co_ovr", 32'(ovr0), 32'd0);
    chk("co_data", 32'(data0), 32'h22);
    chk("co_fcnt", 32'(fcnt0), 32'd2);
    pop_raw("co2_raw");

    // reset mid-shift
    tx0 = 16'h3333;
    wait_for(2, 0, 50);
    rb = rise0;
    wait_for(3, 5, 100);
    rst = 1'b1;
    cont0 = 1'b0;
    step(1);
    rst = 1'b0;
    chk("mr_csn", 32'(cs_n0), 32'd1);
    chk("mr_sclk", 32'(sclk0), 32'd1);
    chk("mr_busy", 32'(busy0), 32'd0);
    chk("mr_dv", 32'(dv0), 32'd0);
    chk("mr_fcnt", 32'(fcnt0), 32'd0);
    step(3);
    tx0 = 16'h5A3C;
    exp_q.push_back(16'h5A3C);
    lb = low0; rb = rise0;
    pulse_start0();
    wait_for(0, 0, 200);
    chk("mr_low_cyc", 32'(low0 - lb), 32'd68);
    chk("mr_rises", 32'(rise0 - rb), 32'd16);
    pop_raw("mr_raw");
    chk("mr_data", 32'(data0), 32'hA3);
    chk("mr_fcnt1", 32'(fcnt0), 32'd1);

    // 12-bit, CLK_DIV=1, start held through the frame
    tx1 = 12'hFA5;
    lb = low1; rb = rise1;
    start1 = 1'b1;
    step(28);
    chk("p_busy_mid", 32'(busy1), 32'd1);
    start1 = 1'b0;
    wait_for(4, 0, 100);
    chk("p_low_cyc", 32'(low1 - lb), 32'd28);
    chk("p_rises", 32'(rise1 - rb), 32'd12);
    chk("p_data", 32'(data1), 32'hFA5);
    chk("p_raw", 32'(raw1), 32'hFA5);
    chk("p_fcnt", 32'(fcnt1), 32'd1);
    step(10);
    chk("p_idle_csn", 32'(cs_n1), 32'd1);
    chk("p_idle_busy", 32'(busy1), 32'd0);
    chk("p_fcnt_end", 32'(fcnt1), 32'd1);

    chk("sb_empty", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
